// File: rtl/memory_interface_pkg.sv
// memory_interface_pkg: constants and types shared by the memory interface.
//   - RV32I LOAD/STORE funct3 encodings (access size and sign)
//   - FSM state enumeration for memory_interface
//   - helper that sign/zero-extends an extracted byte or halfword
package memory_interface_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RDATA,
    ST_DONE
  } mem_state_t;

  // Extend a byte (value[7:0]) or halfword (value[15:0]) to 32 bits.
  function automatic logic [31:0] extend_load(input logic [15:0] value,
                                              input logic        is_half,
                                              input logic        sign_ext);
    if (is_half) begin
      return sign_ext ? {{16{value[15]}}, value} : {16'h0000, value};
    end
    return sign_ext ? {{24{value[7]}}, value[7:0]} : {24'h000000, value[7:0]};
  endfunction

endpackage

// File: rtl/memory_interface_load_store_align.sv
// load_store_align: purely combinational data formatting for memory_interface.
//   addr, funct3, is_store : access being checked or performed
//   wdata                  : raw store data (low bits significant for SB/SH)
//   rdata                  : raw RAM read word
//   store_wdata, store_be  : lane-positioned store data and byte enables
//   load_data              : byte/halfword/word extracted and extended
//   misaligned, illegal    : alignment and funct3 legality faults
//   out_of_range           : byte address beyond DEPTH_WORDS*4-1
module load_store_align
  import memory_interface_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_be,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic        out_of_range
);

  // One bit wider than the address so the limit cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  assign out_of_range = ({1'b0, addr} >= ADDR_LIMIT);

  // Byte lanes: SB replicates the byte into every lane, SH replicates the
  // halfword into both halves, SW passes each lane straight through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_wdata[gi*8 +: 8] =
          (funct3 == F3_SB) ? wdata[7:0] :
          (funct3 == F3_SH) ? wdata[(gi % 2)*8 +: 8] :
                              wdata[gi*8 +: 8];

      assign store_be[gi] = is_store &&
          (((funct3 == F3_SB) && (addr[1:0] == 2'(gi))) ||
           ((funct3 == F3_SH) && (addr[1] == 1'(gi / 2))) ||
            (funct3 == F3_SW));
    end
  endgenerate

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   misaligned = 1'b0;
        F3_SH:   misaligned = addr[0];
        F3_SW:   misaligned = |addr[1:0];
        default: illegal    = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: misaligned = 1'b0;
        F3_LH, F3_LHU: misaligned = addr[0];
        F3_LW:         misaligned = |addr[1:0];
        default:       illegal    = 1'b1;
      endcase
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr[1:0])
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   load_data = extend_load({8'h00, byte_sel}, 1'b0, 1'b1);
      F3_LBU:  load_data = extend_load({8'h00, byte_sel}, 1'b0, 1'b0);
      F3_LH:   load_data = extend_load(half_sel, 1'b1, 1'b1);
      F3_LHU:  load_data = extend_load(half_sel, 1'b1, 1'b0);
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_interface.sv
// memory_interface: responder for the core's memory request interface.
// Accepts one read or write at a time, formats it for a single-port
// synchronous RAM with byte enables, and reports faults without touching RAM.
//   clk, rst_n                    : clock, synchronous active-low reset
//   mem_read, mem_write           : level requests (write wins if both high)
//   mem_addr, mem_wdata, mem_funct3 : request payload, captured at acceptance
//   mem_rdata                     : extended load result, held between reads
//   mem_complete_read/_write      : one-cycle completion pulses
//   mem_fault                     : qualifies a completion as faulted
//   ram_addr/wdata/be/we/re       : RAM command side
//   ram_rdata                     : RAM read data, RAM_LATENCY after ram_re
module memory_interface
  import memory_interface_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mem_read,
  input  logic                           mem_write,
  input  logic [31:0]                    mem_addr,
  input  logic [31:0]                    mem_wdata,
  input  logic [2:0]                     mem_funct3,
  output logic [31:0]                    mem_rdata,
  output logic                           mem_complete_read,
  output logic                           mem_complete_write,
  output logic                           mem_fault,
  output logic [$clog2(DEPTH_WORDS)-1:0] ram_addr,
  output logic [31:0]                    ram_wdata,
  output logic [3:0]                     ram_be,
  output logic                           ram_we,
  output logic                           ram_re,
  input  logic [31:0]                    ram_rdata
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0]  LAT_LAST  = 2'(RAM_LATENCY - 1);

  mem_state_t  state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        write_reg;
  logic        fault_reg;
  logic [3:0]  wait_cnt_reg;
  logic [1:0]  lat_cnt_reg;
  logic [31:0] mem_rdata_reg;

  logic        idle;
  logic [31:0] chk_addr;
  logic [2:0]  chk_funct3;
  logic        chk_store;
  logic [31:0] store_wdata;
  logic [3:0]  store_be;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        out_of_range;
  logic        access_fault;
  logic        access;

  assign idle = (state_reg == ST_IDLE);

  // The aligner checks the live request while idle (fault decision at
  // acceptance) and the captured request otherwise (formatting/extraction).
  assign chk_addr   = idle ? mem_addr   : addr_reg;
  assign chk_funct3 = idle ? mem_funct3 : funct3_reg;
  assign chk_store  = idle ? mem_write  : write_reg;

  load_store_align #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_align (
    .addr         (chk_addr),
    .funct3       (chk_funct3),
    .is_store     (chk_store),
    .wdata        (wdata_reg),
    .rdata        (ram_rdata),
    .store_wdata  (store_wdata),
    .store_be     (store_be),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .illegal      (illegal),
    .out_of_range (out_of_range)
  );

  assign access_fault = misaligned | illegal | out_of_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      funct3_reg    <= '0;
      write_reg     <= 1'b0;
      fault_reg     <= 1'b0;
      wait_cnt_reg  <= '0;
      lat_cnt_reg   <= '0;
      mem_rdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            addr_reg     <= mem_addr;
            wdata_reg    <= mem_wdata;
            funct3_reg   <= mem_funct3;
            write_reg    <= mem_write;
            fault_reg    <= access_fault;
            wait_cnt_reg <= '0;
            if (access_fault) begin
              state_reg <= ST_DONE;
            end else if (WAIT_STATES > 0) begin
              state_reg <= ST_WAIT;
            end else begin
              state_reg <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg <= ST_ACCESS;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        ST_ACCESS: begin
          lat_cnt_reg <= '0;
          state_reg   <= write_reg ? ST_DONE : ST_RDATA;
        end
        ST_RDATA: begin
          if (lat_cnt_reg == LAT_LAST) begin
            mem_rdata_reg <= load_data;
            state_reg     <= ST_DONE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are qualified with rst_n so a reset asserted during the access
  // cycle itself still suppresses the RAM command.
  assign access = (state_reg == ST_ACCESS) && rst_n;
  assign ram_we = access && write_reg;
  assign ram_re = access && !write_reg;

  assign ram_addr  = addr_reg[ADDR_W+1:2];
  assign ram_wdata = ram_we ? store_wdata : 32'h0;
  assign ram_be    = ram_we ? store_be    : 4'h0;

  assign mem_rdata          = mem_rdata_reg;
  assign mem_complete_read  = (state_reg == ST_DONE) && !write_reg;
  assign mem_complete_write = (state_reg == ST_DONE) && write_reg;
  assign mem_fault          = (state_reg == ST_DONE) && fault_reg;

endmodule

// File: tb/tb_memory_interface.sv
module tb_memory_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // DUT A: default parameters (WAIT_STATES=0, RAM_LATENCY=1)
  logic        rst_n, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_wdata, ram_rdata;
  logic [2:0]  mem_funct3;
  logic        mem_complete_read, mem_complete_write, mem_fault, ram_we, ram_re;
  logic [11:0] ram_addr;
  logic [3:0]  ram_be;
  logic [84:0] outs_a;

  // DUT B: WAIT_STATES=2, RAM_LATENCY=3
  logic        rst_n_ws, mem_read_ws, mem_write_ws;
  logic [31:0] mem_addr_ws, mem_wdata_ws, mem_rdata_ws, ram_wdata_ws, ram_rdata_ws;
  logic [2:0]  mem_funct3_ws;
  logic        mem_complete_read_ws, mem_complete_write_ws, mem_fault_ws, ram_we_ws, ram_re_ws;
  logic [11:0] ram_addr_ws;
  logic [3:0]  ram_be_ws;
  logic [84:0] outs_b;
  int          we_count_ws = 0;

  memory_interface u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_rdata(mem_rdata), .mem_complete_read(mem_complete_read),
    .mem_complete_write(mem_complete_write), .mem_fault(mem_fault),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  memory_interface #(.DEPTH_WORDS(4096), .WAIT_STATES(2), .RAM_LATENCY(3)) u_dut_ws (
    .clk(clk), .rst_n(rst_n_ws), .mem_read(mem_read_ws), .mem_write(mem_write_ws),
    .mem_addr(mem_addr_ws), .mem_wdata(mem_wdata_ws), .mem_funct3(mem_funct3_ws),
    .mem_rdata(mem_rdata_ws), .mem_complete_read(mem_complete_read_ws),
    .mem_complete_write(mem_complete_write_ws), .mem_fault(mem_fault_ws),
    .ram_addr(ram_addr_ws), .ram_wdata(ram_wdata_ws), .ram_be(ram_be_ws),
    .ram_we(ram_we_ws), .ram_re(ram_re_ws), .ram_rdata(ram_rdata_ws)
  );

  assign outs_a = {mem_rdata, mem_complete_read, mem_complete_write, mem_fault,
                   ram_addr, ram_wdata, ram_be, ram_we, ram_re};
  assign outs_b = {mem_rdata_ws, mem_complete_read_ws, mem_complete_write_ws, mem_fault_ws,
                   ram_addr_ws, ram_wdata_ws, ram_be_ws, ram_we_ws, ram_re_ws};

  // RAM model A: registered read, 1-cycle latency
  logic [31:0] ram_a [0:4095];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_a[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (ram_re) ram_rdata <= ram_a[ram_addr];
  end

  // RAM model B: 3-cycle latency; data is valid only in the one cycle
  logic [31:0] ram_b [0:4095];
  logic [31:0] pipe1, pipe2;
  always @(posedge clk) begin
    if (ram_we_ws) begin
      for (int b = 0; b < 4; b++)
        if (ram_be_ws[b]) ram_b[ram_addr_ws][b*8 +: 8] <= ram_wdata_ws[b*8 +: 8];
      we_count_ws <= we_count_ws + 1;
    end
    pipe1        <= ram_re_ws ? ram_b[ram_addr_ws] : 32'h0;
    pipe2        <= pipe1;
    ram_rdata_ws <= pipe2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_funct3 = '0;
    rst_n_ws = 1'b0; mem_read_ws = 1'b0; mem_write_ws = 1'b0; mem_addr_ws = '0; mem_wdata_ws = '0; mem_funct3_ws = '0;
    step(); step();
    checks++; if (outs_a !== 85'h0) begin fails++; $display("FAIL reset_outs_a: got %h expected 0", outs_a); end
    checks++; if (outs_b !== 85'h0) begin fails++; $display("FAIL reset_outs_b: got %h expected 0", outs_b); end
    rst_n = 1'b1; rst_n_ws = 1'b1;
    step();
    checks++; if (outs_a !== 85'h0) begin fails++; $display("FAIL idle_outs_a: got %h expected 0", outs_a); end
    $display("reset: outputs idle");
  endtask

  task automatic test_word();
    // SW 0x10 <= 0xDEADBEEF
    mem_write = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
    step();
    mem_write = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    checks++; if (ram_we !== 1'b1) begin fails++; $display("FAIL sw_we: got %b expected 1", ram_we); end
    checks++; if (ram_be !== 4'hF) begin fails++; $display("FAIL sw_be: got %b expected 1111", ram_be); end
    checks++; if (ram_addr !== 12'h004) begin fails++; $display("FAIL sw_addr: got %h expected 004", ram_addr); end
    checks++; if (ram_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata: got %h expected deadbeef", ram_wdata); end
    step();
    checks++; if ({mem_complete_write, mem_fault} !== 2'b10) begin fails++; $display("FAIL sw_complete: got %b expected 10", {mem_complete_write, mem_fault}); end
    step();
    $display("SW 0x10 0xdeadbeef done");
    // LW 0x10
    mem_read = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h10;
    step();
    mem_read = 1'b0;
    checks++; if ({ram_re, ram_be} !== 5'b1_0000) begin fails++; $display("FAIL lw_re: got %b expected 10000", {ram_re, ram_be}); end
    step();
    checks++; if (mem_complete_read !== 1'b0) begin fails++; $display("FAIL lw_early: got %b expected 0", mem_complete_read); end
    step();
    checks++; if ({mem_complete_read, mem_fault} !== 2'b10) begin fails++; $display("FAIL lw_complete: got %b expected 10", {mem_complete_read, mem_fault}); end
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got %h expected deadbeef", mem_rdata); end
    step();
    $display("LW 0x10 -> %h", mem_rdata);
  endtask

  task automatic test_byte();
    // SB 0x13 <= 0x80 (upper wdata bits must be ignored)
    mem_write = 1'b1; mem_funct3 = 3'b000; mem_addr = 32'h13; mem_wdata = 32'hAAAAAA80;
    step();
    mem_write = 1'b0;
    checks++; if (ram_be !== 4'b1000) begin fails++; $display("FAIL sb_be: got %b expected 1000", ram_be); end
    checks++; if (ram_wdata !== 32'h80808080) begin fails++; $display("FAIL sb_wdata: got %h expected 80808080", ram_wdata); end
    step();
    checks++; if (mem_complete_write !== 1'b1) begin fails++; $display("FAIL sb_complete: got %b expected 1", mem_complete_write); end
    step();
    $display("SB 0x13 0x80 done");
    // LB 0x13
    mem_read = 1'b1; mem_funct3 = 3'b000; mem_addr = 32'h13;
    step(); mem_read = 1'b0; step(); step();
    checks++; if ({mem_complete_read, mem_rdata} !== {1'b1, 32'hFFFFFF80}) begin fails++; $display("FAIL lb_rdata: got %b %h expected 1 ffffff80", mem_complete_read, mem_rdata); end
    step();
    $display("LB 0x13 -> %h", mem_rdata);
    // LBU 0x13
    mem_read = 1'b1; mem_funct3 = 3'b100; mem_addr = 32'h13;
    step(); mem_read = 1'b0; step(); step();
    checks++; if ({mem_complete_read, mem_rdata} !== {1'b1, 32'h00000080}) begin fails++; $display("FAIL lbu_rdata: got %b %h expected 1 00000080", mem_complete_read, mem_rdata); end
    step();
    $display("LBU 0x13 -> %h", mem_rdata);
  endtask

  task automatic test_fault();
    // LW misaligned 0x22
    mem_read = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h22;
    step();
    mem_read = 1'b0;
    checks++; if ({mem_complete_read, mem_fault, ram_re} !== 3'b110) begin fails++; $display("FAIL lw_misalign: got %b expected 110", {mem_complete_read, mem_fault, ram_re}); end
    checks++; if (mem_rdata !== 32'h00000080) begin fails++; $display("FAIL lw_misalign_rdata: got %h expected 00000080", mem_rdata); end
    step();
    checks++; if ({mem_complete_read, mem_fault, ram_re} !== 3'b000) begin fails++; $display("FAIL lw_misalign_after: got %b expected 000", {mem_complete_read, mem_fault, ram_re}); end
    $display("LW 0x22 faulted");
    // SW out of range 0x4000
    mem_write = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h4000; mem_wdata = 32'h12345678;
    step();
    mem_write = 1'b0;
    checks++; if ({mem_complete_write, mem_fault, ram_we} !== 3'b110) begin fails++; $display("FAIL sw_range: got %b expected 110", {mem_complete_write, mem_fault, ram_we}); end
    step();
    $display("SW 0x4000 faulted");
    // Illegal load funct3 011
    mem_read = 1'b1; mem_funct3 = 3'b011; mem_addr = 32'h0;
    step();
    mem_read = 1'b0;
    checks++; if ({mem_complete_read, mem_fault} !== 2'b11) begin fails++; $display("FAIL ld_illegal: got %b expected 11", {mem_complete_read, mem_fault}); end
    step();
    $display("load funct3 011 faulted");
    // SH misaligned 0x11
    mem_write = 1'b1; mem_funct3 = 3'b001; mem_addr = 32'h11;
    step();
    mem_write = 1'b0;
    checks++; if ({mem_complete_write, mem_fault, ram_we} !== 3'b110) begin fails++; $display("FAIL sh_misalign: got %b expected 110", {mem_complete_write, mem_fault, ram_we}); end
    step();
    $display("SH 0x11 faulted");
  endtask

  task automatic test_wait_latency();
    // SW 0x10 <= 0x7FFF1234 on the wait-state instance: complete at T+4
    mem_write_ws = 1'b1; mem_funct3_ws = 3'b010; mem_addr_ws = 32'h10; mem_wdata_ws = 32'h7FFF1234;
    step(); mem_write_ws = 1'b0;
    step();
    checks++; if (ram_we_ws !== 1'b0) begin fails++; $display("FAIL ws_we_wait: got %b expected 0", ram_we_ws); end
    step();
    checks++; if ({ram_we_ws, ram_addr_ws} !== {1'b1, 12'h004}) begin fails++; $display("FAIL ws_we_access: got %b %h expected 1 004", ram_we_ws, ram_addr_ws); end
    step();
    checks++; if (mem_complete_write_ws !== 1'b1) begin fails++; $display("FAIL ws_sw_complete: got %b expected 1", mem_complete_write_ws); end
    step();
    $display("WS SW 0x10 0x7fff1234 done");
    // LH 0x12: complete at T+7
    mem_read_ws = 1'b1; mem_funct3_ws = 3'b001; mem_addr_ws = 32'h12;
    step(); mem_read_ws = 1'b0;
    for (int i = 2; i <= 6; i++) step();
    checks++; if (mem_complete_read_ws !== 1'b0) begin fails++; $display("FAIL ws_lh_early: got %b expected 0", mem_complete_read_ws); end
    step();
    checks++; if ({mem_complete_read_ws, mem_fault_ws} !== 2'b10) begin fails++; $display("FAIL ws_lh_complete: got %b expected 10", {mem_complete_read_ws, mem_fault_ws}); end
    checks++; if (mem_rdata_ws !== 32'h00007FFF) begin fails++; $display("FAIL ws_lh_rdata: got %h expected 00007fff", mem_rdata_ws); end
    step();
    $display("WS LH 0x12 -> %h", mem_rdata_ws);
  endtask

  task automatic test_back_to_back();
    // Word 4 now holds 0x80ADBEEF (SB to 0x13 over 0xDEADBEEF)
    mem_read = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h10;
    for (int i = 1; i <= 11; i++) begin
      step();
      checks++; if (mem_complete_read !== ((i % 4) == 3)) begin fails++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, mem_complete_read, ((i % 4) == 3)); end
      if (i == 11) mem_read = 1'b0;
    end
    checks++; if (mem_rdata !== 32'h80ADBEEF) begin fails++; $display("FAIL b2b_rdata: got %h expected 80adbeef", mem_rdata); end
    step();
    $display("held read: 3 completions, rdata %h", mem_rdata);
    // Simultaneous read + write: write wins
    mem_read = 1'b1; mem_write = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h14; mem_wdata = 32'h11223344;
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    checks++; if ({ram_we, ram_re} !== 2'b10) begin fails++; $display("FAIL rw_strobes: got %b expected 10", {ram_we, ram_re}); end
    step();
    checks++; if ({mem_complete_write, mem_complete_read} !== 2'b10) begin fails++; $display("FAIL rw_complete: got %b expected 10", {mem_complete_write, mem_complete_read}); end
    step();
    checks++; if (mem_complete_read !== 1'b0) begin fails++; $display("FAIL rw_no_read: got %b expected 0", mem_complete_read); end
    $display("read+write: write only");
  endtask

  task automatic test_reset_mid();
    int we_before;
    // Known contents at 0x20
    mem_write_ws = 1'b1; mem_funct3_ws = 3'b010; mem_addr_ws = 32'h20; mem_wdata_ws = 32'h01020304;
    step(); mem_write_ws = 1'b0; step(); step(); step();
    checks++; if (mem_complete_write_ws !== 1'b1) begin fails++; $display("FAIL pre_sw_complete: got %b expected 1", mem_complete_write_ws); end
    step();
    we_before = we_count_ws;
    // SW aborted by reset while waiting
    mem_write_ws = 1'b1; mem_funct3_ws = 3'b010; mem_addr_ws = 32'h20; mem_wdata_ws = 32'hCAFEF00D;
    step();
    mem_write_ws = 1'b0; rst_n_ws = 1'b0;
    checks++; if (ram_we_ws !== 1'b0) begin fails++; $display("FAIL rst_we_now: got %b expected 0", ram_we_ws); end
    step();
    checks++; if (outs_b !== 85'h0) begin fails++; $display("FAIL rst_mid_outs: got %h expected 0", outs_b); end
    rst_n_ws = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (we_count_ws !== we_before) begin fails++; $display("FAIL rst_no_write: got %0d writes expected %0d", we_count_ws, we_before); end
    // New request accepted after reset; RAM must still hold the old word
    mem_read_ws = 1'b1; mem_funct3_ws = 3'b010; mem_addr_ws = 32'h20;
    step(); mem_read_ws = 1'b0;
    for (int i = 2; i <= 7; i++) step();
    checks++; if ({mem_complete_read_ws, mem_rdata_ws} !== {1'b1, 32'h01020304}) begin fails++; $display("FAIL rst_after_lw: got %b %h expected 1 01020304", mem_complete_read_ws, mem_rdata_ws); end
    step();
    $display("reset during WAIT: write suppressed, LW 0x20 -> %h", mem_rdata_ws);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_fault();
    test_wait_latency();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
